// File: rtl/logic_unit_pipe.sv
// Pipelined 3-operand bitwise logic unit. The function is evaluated per bit at the input,
// then the result and its valid bit move through STAGES registers under one global advance.

module logic_unit_lane (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       c_i,
    input  logic [2:0] op_i,
    output logic       y_o
);
    always_comb begin
        y_o = 1'b0;
        case (op_i)
            3'd0: y_o = a_i & b_i;
            3'd1: y_o = b_i | c_i;
            3'd2: y_o = a_i ^ b_i ^ c_i;
            3'd3: y_o = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
            3'd4: y_o = ~(a_i & b_i);
            3'd5: y_o = (a_i & b_i) | c_i;
            3'd6: y_o = c_i ? b_i : a_i;
            3'd7: y_o = a_i;
            default: y_o = 1'b0;
        endcase
    end
endmodule

module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             out_valid,
    input  logic             out_ready
);
    logic                          adv;
    logic [WIDTH-1:0]              fn;
    logic [STAGES:0]               vld_pipe;
    logic [STAGES:0][WIDTH-1:0]    res_pipe;
    logic [STAGES:1]               vld_q;
    logic [STAGES:1][WIDTH-1:0]    res_q;
    logic                          zero_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic_unit_lane u_lane (
            .a_i  (a[i]),
            .b_i  (b[i]),
            .c_i  (c[i]),
            .op_i (op),
            .y_o  (fn[i])
        );
    end

    // Index 0 is the combinational input side; 1..STAGES are the registers.
    assign vld_pipe = {vld_q, in_valid & adv};
    assign res_pipe = {res_q, fn};

    // Whole pipe moves or holds as one; bubbles are carried, never squeezed out.
    assign adv      = ~vld_pipe[STAGES] | out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else if (adv) begin
            vld_q  <= vld_pipe[STAGES-1:0];
            res_q  <= res_pipe[STAGES-1:0];
            zero_q <= (res_pipe[STAGES-1] == '0);
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign y         = res_pipe[STAGES];
    assign y_zero    = zero_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench: drivers push expected results, one monitor pops on every output transfer.
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] a, b, c, y;
    logic [2:0] op;
    logic in_valid, in_ready, out_valid, out_ready, y_zero;

    logic [0:0] a1, b1, c1, y1;
    logic [2:0] op1;
    logic iv1, ir1, ov1, or1, z1;

    logic [15:0] a16, b16, c16, y16;
    logic [2:0] op16;
    logic iv16, ir16, ov16, or16, z16;

    logic_unit_pipe #(.WIDTH(8), .STAGES(2)) u8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .op(op), .in_valid(in_valid),
        .in_ready(in_ready), .y(y), .y_zero(y_zero), .out_valid(out_valid), .out_ready(out_ready));
    logic_unit_pipe #(.WIDTH(1), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .op(op1), .in_valid(iv1),
        .in_ready(ir1), .y(y1), .y_zero(z1), .out_valid(ov1), .out_ready(or1));
    logic_unit_pipe #(.WIDTH(16), .STAGES(4)) u16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .c(c16), .op(op16), .in_valid(iv16),
        .in_ready(ir16), .y(y16), .y_zero(z16), .out_valid(ov16), .out_ready(or16));

    typedef struct { logic [15:0] y; logic z; int cyc; bit chk; } exp_t;
    exp_t q8[$], q1[$], q16[$];
    int n_cmp = 0, n_bad = 0;
    bit lat_chk = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic cmp_out(input string nm, input exp_t e, input logic [15:0] ay, input logic az,
                           input int lat);
        chk({nm, " y"}, 32'(ay), 32'(e.y));
        chk({nm, " y_zero"}, 32'(az), 32'(e.z));
        if (e.chk) chk({nm, " latency"}, 32'(cyc - e.cyc), 32'(lat));
    endtask

    function automatic logic [15:0] ref_f(input logic [15:0] fa, fb, fc, input logic [2:0] fop);
        case (fop)
            3'd0: return fa & fb;
            3'd1: return fb | fc;
            3'd2: return fa ^ fb ^ fc;
            3'd3: return (fa & fb) | (fb & fc) | (fa & fc);
            3'd4: return ~(fa & fb);
            3'd5: return (fa & fb) | fc;
            3'd6: return (fc & fb) | (~fc & fa);
            default: return fa;
        endcase
    endfunction

    // Monitor: samples late in the low phase, when inputs and outputs are settled.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (out_valid && !out_ready) chk("stall in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (q8.size() == 0) fail_now("u8 unexpected output");
                else cmp_out("u8", q8.pop_front(), {8'h00, y}, y_zero, 2);
            end
            if (ov1 && or1) begin
                if (q1.size() == 0) fail_now("u1 unexpected output");
                else cmp_out("u1", q1.pop_front(), {15'h0, y1}, z1, 1);
            end
            if (ov16 && or16) begin
                if (q16.size() == 0) fail_now("u16 unexpected output");
                else cmp_out("u16", q16.pop_front(), y16, z16, 4);
            end
        end
    end

    // Called just after a falling edge; holds operands until taken, returns at the next falling edge.
    task automatic send(input logic [7:0] ta, tb_, tc, input logic [2:0] top, input logic [7:0] ey);
        exp_t e;
        a = ta; b = tb_; c = tc; op = top; in_valid = 1'b1;
        #1;
        for (int t = 0; !in_ready; t++) begin
            if (t == 50) begin
                fail_now("u8 send timeout");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        e.y = {8'h00, ey}; e.z = (ey == 8'h00); e.cyc = cyc; e.chk = lat_chk;
        q8.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_aux;
        exp_t e;
        if (iv1 && ir1) begin
            e.y = ref_f({15'h0, a1}, {15'h0, b1}, {15'h0, c1}, op1) & 16'h0001;
            e.z = (e.y == 16'h0); e.cyc = cyc; e.chk = lat_chk;
            q1.push_back(e);
        end
        if (iv16 && ir16) begin
            e.y = ref_f(a16, b16, c16, op16);
            e.z = (e.y == 16'h0); e.cyc = cyc; e.chk = lat_chk;
            q16.push_back(e);
        end
    endtask

    // Hand-derived for a=F0 b=CC c=AA; op6 picks b where c=1: 88|50 = D8.
    logic [7:0] t2 [8] = '{8'hC0, 8'hEE, 8'h96, 8'hE8, 8'h3F, 8'hEA, 8'hD8, 8'hF0};

    initial begin
        int t;
        bit acc1, acc16;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; op = '0;
        {a1, b1, c1, op1, iv1} = '0; or1 = 1'b1;
        {a16, b16, c16, op16, iv16} = '0; or16 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset y", 32'(y), 32'd0);
        chk("reset y_zero", 32'(y_zero), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // T2: all eight functions back to back, fixed latency
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) send(8'hF0, 8'hCC, 8'hAA, 3'(i), t2[i]);
        idle(4);

        // T3: zero flag
        send(8'h0F, 8'hF0, 8'h00, 3'd0, 8'h00);
        send(8'h0F, 8'hF0, 8'h00, 3'd7, 8'h0F);
        idle(4);

        // T1: reset with results in flight, then immediate first transfer
        lat_chk = 1'b0;
        send(8'h11, 8'h00, 8'h00, 3'd7, 8'h11);
        send(8'h22, 8'h00, 8'h00, 3'd7, 8'h22);
        rst = 1'b1;
        q8.delete();
        #1;
        chk("mid-stream reset out_valid", 32'(out_valid), 32'd0);
        chk("mid-stream reset y", 32'(y), 32'd0);
        chk("mid-stream reset y_zero", 32'(y_zero), 32'd0);
        chk("mid-stream reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        lat_chk = 1'b1;
        send(8'h5A, 8'h00, 8'h00, 3'd7, 8'h5A);
        chk("no stale output after reset", 32'(out_valid), 32'd0);
        idle(4);

        // T4: backpressure for 3 cycles after the first result shows up
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send(8'(i), 8'h00, 8'h00, 3'd7, 8'(i));
            end
            begin
                t = 0;
                while (!out_valid && t < 20) begin @(negedge clk); t++; end
                if (!out_valid) fail_now("T4 first out_valid timeout");
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle(6);
        chk("T4 all outputs consumed", 32'(q8.size()), 32'd0);

        // T6: continuous in/out transfers; fixed latency means no gaps, no duplicates
        lat_chk = 1'b1;
        for (int i = 0; i < 20; i++)
            send(8'(i * 7), 8'hFF, 8'h00, (i % 2 == 0) ? 3'd7 : 3'd0, 8'(i * 7));
        idle(4);
        lat_chk = 1'b0;

        // T5: random traffic on the narrow/shallow and wide/deep variants
        acc1 = 1'b1; acc16 = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (!iv1 || acc1) begin
                a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
                op1 = 3'($urandom); iv1 = 1'($urandom);
            end
            if (!iv16 || acc16) begin
                a16 = 16'($urandom); b16 = 16'($urandom); c16 = 16'($urandom);
                op16 = 3'($urandom); iv16 = 1'($urandom);
            end
            or1 = 1'($urandom); or16 = 1'($urandom);
            #1;
            acc1 = iv1 && ir1; acc16 = iv16 && ir16;
            push_aux();
            @(negedge clk);
        end
        iv1 = 1'b0; iv16 = 1'b0; or1 = 1'b1; or16 = 1'b1;
        t = 0;
        while ((q1.size() != 0 || q16.size() != 0) && t < 20) begin @(negedge clk); t++; end
        chk("T5 u1 drained", 32'(q1.size()), 32'd0);
        chk("T5 u16 drained", 32'(q16.size()), 32'd0);

        // Unstalled latency on both variants
        lat_chk = 1'b1;
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; op1 = 3'd6; iv1 = 1'b1;
        a16 = 16'h1234; b16 = 16'h00FF; c16 = 16'hF000; op16 = 3'd5; iv16 = 1'b1;
        #1;
        if (!(ir1 && ir16)) fail_now("T5 in_ready low with empty pipe");
        push_aux();
        @(negedge clk);
        iv1 = 1'b0; iv16 = 1'b0;
        t = 0;
        while ((q1.size() != 0 || q16.size() != 0 || q8.size() != 0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        #3;
        chk("final u8 queue empty", 32'(q8.size()), 32'd0);
        chk("final u1 queue empty", 32'(q1.size()), 32'd0);
        chk("final u16 queue empty", 32'(q16.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
